// File: rtl/mem_port_ctrl.sv
// Per-core memory port controller: one load/store/lock/unlock at a time.
// Optional grant/ack wait timeout enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_adr,
    input  logic [15:0] cmd_dat,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_dat,
    output logic        rsp_err,
    output logic        main_mem_read_request,
    output logic        main_mem_write_request,
    output logic        main_mem_read,
    output logic        main_mem_write,
    output logic [15:0] main_mem_read_adr,
    output logic [15:0] main_mem_write_adr,
    output logic [15:0] main_mem_write_dat,
    input  logic        main_mem_ac,
    input  logic [15:0] main_mem_dat,
    output logic [9:0]  lock_adr,
    output logic        lock_en,
    output logic        unlock_en,
    input  logic        lock_ac
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_LOCK   = 2'b10;
    localparam logic [1:0] OP_UNLOCK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACCESS,
        RDATA,
        LOCKW,
        DONE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [1:0] op_q;
    logic [1:0] op_n;
    logic       accept;
    logic       expire;
    logic       to_err;

`ifdef MEM_PORT_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counter is zero in the first wait cycle, so expiry is on its last one.
    assign expire = (({1'b0, wait_cnt} + 9'd1) == TIMEOUT[8:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (state == REQ || state == LOCKW) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        nxt    = state;
        op_n   = op_q;
        accept = 1'b0;
        to_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    op_n   = cmd_op;
                    nxt    = cmd_op[1] ? LOCKW : REQ;
                end
            end
            REQ: begin
                if (main_mem_ac) begin
                    nxt = ACCESS;
                end else if (expire) begin
                    nxt    = DONE;
                    to_err = 1'b1;
                end
            end
            ACCESS: begin
                nxt = (op_q == OP_LOAD) ? RDATA : DONE;
            end
            RDATA: begin
                nxt = DONE;
            end
            LOCKW: begin
                if (lock_ac) begin
                    nxt = DONE;
                end else if (expire) begin
                    nxt    = DONE;
                    to_err = 1'b1;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            op_q                   <= OP_LOAD;
            cmd_ready              <= 1'b0;
            rsp_valid              <= 1'b0;
            rsp_dat                <= 16'd0;
            rsp_err                <= 1'b0;
            main_mem_read_request  <= 1'b0;
            main_mem_write_request <= 1'b0;
            main_mem_read          <= 1'b0;
            main_mem_write         <= 1'b0;
            main_mem_read_adr      <= 16'd0;
            main_mem_write_adr     <= 16'd0;
            main_mem_write_dat     <= 16'd0;
            lock_adr               <= 10'd0;
            lock_en                <= 1'b0;
            unlock_en              <= 1'b0;
        end else begin
            state     <= nxt;
            op_q      <= op_n;
            cmd_ready <= (nxt == IDLE);
            rsp_valid <= (nxt == DONE);
            rsp_err   <= to_err;
            rsp_dat   <= (state == RDATA) ? main_mem_dat : 16'd0;

            main_mem_read_request  <= (op_n == OP_LOAD) &&
                                      (nxt == REQ || nxt == ACCESS);
            main_mem_write_request <= (op_n == OP_STORE) &&
                                      (nxt == REQ || nxt == ACCESS);
            main_mem_read          <= (op_n == OP_LOAD) &&
                                      (nxt == ACCESS || nxt == RDATA);
            main_mem_write         <= (op_n == OP_STORE) && (nxt == ACCESS);
            lock_en                <= (op_n == OP_LOCK) && (nxt == LOCKW);
            unlock_en              <= (op_n == OP_UNLOCK) && (nxt == LOCKW);

            if (accept) begin
                main_mem_read_adr  <= cmd_adr;
                main_mem_write_adr <= cmd_adr;
                main_mem_write_dat <= cmd_dat;
                lock_adr           <= cmd_adr[9:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: per-cycle timeline model plus
// directed pins; timeout scenarios run when MEM_PORT_TIMEOUT_EN is defined.
module tb_mem_port_ctrl;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int T     = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int T     = 255;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAXC = 8192;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] LK = 2'b10;
    localparam logic [1:0] UL = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_adr;
    logic [15:0] cmd_dat;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [15:0] rsp_dat;
    logic        rsp_err;
    logic        main_mem_read_request;
    logic        main_mem_write_request;
    logic        main_mem_read;
    logic        main_mem_write;
    logic [15:0] main_mem_read_adr;
    logic [15:0] main_mem_write_adr;
    logic [15:0] main_mem_write_dat;
    logic        main_mem_ac;
    logic [15:0] main_mem_dat;
    logic [9:0]  lock_adr;
    logic        lock_en;
    logic        unlock_en;
    logic        lock_ac;

    always #5 clk = ~clk;

    mem_port_ctrl #(.TIMEOUT(T)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cmd_valid              (cmd_valid),
        .cmd_op                 (cmd_op),
        .cmd_adr                (cmd_adr),
        .cmd_dat                (cmd_dat),
        .cmd_ready              (cmd_ready),
        .rsp_valid              (rsp_valid),
        .rsp_dat                (rsp_dat),
        .rsp_err                (rsp_err),
        .main_mem_read_request  (main_mem_read_request),
        .main_mem_write_request (main_mem_write_request),
        .main_mem_read          (main_mem_read),
        .main_mem_write         (main_mem_write),
        .main_mem_read_adr      (main_mem_read_adr),
        .main_mem_write_adr     (main_mem_write_adr),
        .main_mem_write_dat     (main_mem_write_dat),
        .main_mem_ac            (main_mem_ac),
        .main_mem_dat           (main_mem_dat),
        .lock_adr               (lock_adr),
        .lock_en                (lock_en),
        .unlock_en              (unlock_en),
        .lock_ac                (lock_ac)
    );

    typedef struct packed {
        logic        rrq;
        logic        wrq;
        logic        rd;
        logic        wr;
        logic        lk;
        logic        ulk;
        logic        rv;
        logic        err;
        logic        rdy;
        logic [15:0] rdat;
    } ob_t;

    ob_t         exp_q [MAXC];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_adr = 16'd0;
    logic [15:0] m_dat = 16'd0;
    logic [15:0] ref_mem [16];
    logic [15:0] arb_mem [16];
    int          rv_per;
    logic [15:0] rv_dat;
    logic        rv_err;
    logic [24:0] act_v;

    assign act_v = {main_mem_read_request, main_mem_write_request,
                    main_mem_read, main_mem_write, lock_en, unlock_en,
                    rsp_valid, rsp_err, cmd_ready, rsp_dat};

    // Arbiter memory, written by the DUT's store strobe; per-cycle compare.
    always @(posedge clk) begin
        if (main_mem_write === 1'b1)
            arb_mem[main_mem_write_adr[3:0]] <= main_mem_write_dat;
        cyc <= cyc + 1;
        #1;
        if (cyc >= 1 && cyc < MAXC) begin
            tests++;
            if (act_v !== exp_q[cyc]) begin
                fails++;
                $display("FAIL outs cyc=%0d got=%h expected=%h",
                         cyc, act_v, exp_q[cyc]);
            end
            tests++;
            if ({main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
                 lock_adr} !== {m_adr, m_adr, m_dat, m_adr[9:0]}) begin
                fails++;
                $display("FAIL adr cyc=%0d got=%h/%h/%h/%h expected=%h/%h",
                         cyc, main_mem_read_adr, main_mem_write_adr,
                         main_mem_write_dat, lock_adr, m_adr, m_dat);
            end
            if (rsp_valid === 1'b1) begin
                rv_per = cyc;
                rv_dat = rsp_dat;
                rv_err = rsp_err;
            end
        end
    end

    function automatic ob_t idle_e();
        ob_t e;
        e     = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    task automatic pin(input string nm, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic rand_side();
        main_mem_ac  = 1'($urandom);
        lock_ac      = 1'($urandom);
        main_mem_dat = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rand_side();
        end
    endtask

    // Called at the negedge of an idle period; returns at DONE's negedge.
    task automatic issue(input logic [1:0] op, input logic [15:0] adr,
                         input logic [15:0] dat, input int d,
                         input bit hold, output int acc);
        ob_t e;
        int  a;
        int  w;
        int  p;
        int  done;
        bit  to;
        a    = cyc + 1;
        acc  = a;
        to   = TO_EN && (d >= T);
        w    = to ? T : d + 1;
        for (int i = 0; i < w; i++) begin
            e     = '0;
            e.rrq = (op == LD);
            e.wrq = (op == ST);
            e.lk  = (op == LK);
            e.ulk = (op == UL);
            exp_q[a + i] = e;
        end
        p = a + w;
        if (!to && !op[1]) begin
            e     = '0;
            e.rrq = (op == LD);
            e.rd  = (op == LD);
            e.wrq = (op == ST);
            e.wr  = (op == ST);
            exp_q[p] = e;
            p++;
            if (op == LD) begin
                e    = '0;
                e.rd = 1'b1;
                exp_q[p] = e;
                p++;
            end
        end
        e      = '0;
        e.rv   = 1'b1;
        e.err  = to;
        e.rdat = (op == LD && !to) ? ref_mem[adr[3:0]] : 16'd0;
        exp_q[p] = e;
        done = p;
        if (op == ST && !to)
            ref_mem[adr[3:0]] = dat;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_dat   = dat;
        m_adr     = adr;
        m_dat     = dat;
        rand_side();
        for (int q = a; q <= done; q++) begin
            @(negedge clk);
            cmd_valid = hold;
            if (hold) begin
                cmd_op  = 2'($urandom);
                cmd_adr = 16'($urandom);
                cmd_dat = 16'($urandom);
            end
            rand_side();
            if (q < a + w) begin
                if (op[1])
                    lock_ac = !to && (q == a + w - 1);
                else
                    main_mem_ac = !to && (q == a + w - 1);
            end
            if (op == LD && !to && q == a + w + 1)
                main_mem_dat = arb_mem[adr[3:0]];
        end
    endtask

    initial begin
        int acc;
        int d;
        logic [1:0] op;
        for (int i = 0; i < MAXC; i++)
            exp_q[i] = idle_e();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'(i * 16'h1357);
            arb_mem[i] = 16'(i * 16'h1357);
        end
        exp_q[1]  = '0;
        exp_q[2]  = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_adr   = 16'd0;
        cmd_dat   = 16'd0;
        rand_side();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        idle(1);
        rv_per = -1;
        issue(ST, 16'h0010, 16'hBEEF, 0, 1'b0, acc);
        pin("store_lat", rv_per - acc, 2);
        pin("store_err", int'(rv_err), 0);

        idle(1);
        issue(LD, 16'h0010, 16'h0000, 5, 1'b0, acc);
        pin("load_lat", rv_per - acc, 8);
        pin("load_dat", int'(rv_dat), 16'hBEEF);

        idle(2);
        issue(LK, 16'h03FF, 16'h0000, 3, 1'b0, acc);
        pin("lock_lat", rv_per - acc, 4);
        idle(1);
        issue(UL, 16'h03FF, 16'h0000, 0, 1'b0, acc);
        pin("unlock_lat", rv_per - acc, 1);

        idle(1);
        issue(LD, 16'h0010, 16'h0000, 2, 1'b1, acc);
        idle(1);
        issue(ST, 16'h0020, 16'h1234, 0, 1'b0, acc);

        // Reset while the store is in ACCESS; the write itself already issued.
        idle(1);
        acc = cyc + 1;
        exp_q[acc]       = '0;
        exp_q[acc].wrq   = 1'b1;
        exp_q[acc + 1]   = '0;
        exp_q[acc + 1].wrq = 1'b1;
        exp_q[acc + 1].wr  = 1'b1;
        exp_q[acc + 2]   = '0;
        ref_mem[5]       = 16'hCAFE;
        cmd_valid = 1'b1;
        cmd_op    = ST;
        cmd_adr   = 16'h0005;
        cmd_dat   = 16'hCAFE;
        m_adr     = 16'h0005;
        m_dat     = 16'hCAFE;
        rv_per    = -1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        main_mem_ac = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        m_adr = 16'd0;
        m_dat = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pin("rst_ready", int'(cmd_ready), 1);
        pin("rst_no_rsp", rv_per, -1);
        issue(LD, 16'h0005, 16'h0000, 1, 1'b0, acc);
        pin("rst_store_kept", int'(rv_dat), 16'hCAFE);

        if (TO_EN) begin
            idle(1);
            issue(LK, 16'h0123, 16'h0000, 1000, 1'b0, acc);
            pin("to_lock_lat", rv_per - acc, 4);
            pin("to_lock_err", int'(rv_err), 1);
            idle(1);
            issue(LD, 16'h0005, 16'h0000, 3, 1'b0, acc);
            pin("to_edge_lat", rv_per - acc, 6);
            pin("to_edge_err", int'(rv_err), 0);
        end

        for (int n = 0; n < 150; n++) begin
            idle(1 + $urandom_range(0, 2));
            op = 2'($urandom);
            d  = $urandom_range(0, 6);
            if (TO_EN && $urandom_range(0, 4) == 0)
                d = $urandom_range(T - 1, T + 3);
            issue(op, 16'($urandom), 16'($urandom), d,
                  1'($urandom), acc);
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Per-core memory port controller sitting directly upstream of the shared main-memory/mutex arbiter. It accepts one load, store, lock or unlock command at a time from its core. It runs the request/grant handshake with the arbiter and drives the access strobes. It returns read data or completion to the core. One instance exists per core; its arbiter-side outputs form one lane of the arbiter's C-wide request, address and data vectors.

## Interface
- TIMEOUT, 255: grant-wait limit in cycles; only used with MEM_PORT_TIMEOUT_EN.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  core command present.
- cmd_op  in  2  00 LOAD, 01 STORE, 10 LOCK, 11 UNLOCK.
- cmd_adr  in  16  word address; bits [9:0] are the mutex index for LOCK/UNLOCK.
- cmd_dat  in  16  store data.
- cmd_ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_dat  out  16  load data; 0 for other ops.
- rsp_err  out  1  timeout abort flag, valid with rsp_valid.
- main_mem_read_request, main_mem_write_request  out  1  arbiter requests.
- main_mem_read, main_mem_write  out  1  access strobes.
- main_mem_read_adr, main_mem_write_adr  out  16  registered cmd_adr.
- main_mem_write_dat  out  16  registered cmd_dat.
- main_mem_ac  in  1  this lane's grant.
- main_mem_dat  in  16  shared memory read data.
- lock_adr  out  10  registered cmd_adr[9:0].
- lock_en, unlock_en  out  1  mutex requests.
- lock_ac  in  1  this lane's mutex acknowledge.

## Operation
- States: IDLE, REQ, ACCESS, RDATA, LOCKW, DONE.
- IDLE: when cmd_valid is high, latch op, address and data.
  - LOAD/STORE -> REQ.
  - LOCK/UNLOCK -> LOCKW.
- REQ: assert the read or write request matching the op. On main_mem_ac=1 -> ACCESS.
- ACCESS, one cycle: keep the request high and assert the main_mem_read or main_mem_write strobe.
  - STORE -> DONE.
  - LOAD -> RDATA.
- RDATA, one cycle: keep main_mem_read high and capture main_mem_dat into rsp_dat at the end of the cycle -> DONE.
- LOCKW: assert lock_en (LOCK) or unlock_en (UNLOCK) until lock_ac=1, then -> DONE.
  - A LOCK on a held mutex never sees lock_ac. With MEM_PORT_TIMEOUT_EN off it waits indefinitely.
- DONE: rsp_valid=1 for one cycle -> IDLE.
- Request, strobe and lock outputs are registered decodes of state and op. Only one output group is ever active.
- Address and data outputs hold their latched value until the next accepted command.

## Timing
- All outputs reset to 0, state resets to IDLE, and the timeout counter resets to 0.
- Reset mid-operation drops every request and strobe on the next edge and produces no rsp_valid.
- A command is accepted on the edge where cmd_valid and cmd_ready are both high. cmd_ready falls on the following cycle.
- STORE with immediate grant: accept edge plus 3 cycles to rsp_valid (REQ, ACCESS, DONE).
- LOAD with immediate grant: plus 4 cycles (REQ, ACCESS, RDATA, DONE).
- LOCK/UNLOCK with immediate ack: plus 2 cycles.
- Grant delay adds cycles 1:1.
- main_mem_ac sampled low keeps the block in REQ with the request held. The request is never withdrawn before grant unless a timeout fires.
- cmd_valid while busy is ignored, not queued.
- A new command is accepted in the IDLE cycle right after DONE; back-to-back throughput is therefore one command per latency plus 1.

## Configuration
- MEM_PORT_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ or LOCKW and increments each cycle spent waiting.
  - When it reaches TIMEOUT without grant/ack, the request drops and the block goes to DONE with rsp_err=1 and rsp_dat=0.
  - A grant/ack arriving in the same cycle the counter hits TIMEOUT wins; no error is raised.
- MEM_PORT_TIMEOUT_EN undefined: there is no counter, rsp_err is tied 0, and waits are unbounded.

## Test plan
- STORE adr=0x0010 dat=0xBEEF, ac held high -> write request and main_mem_write_adr=0x0010 valid, main_mem_write strobe in cycle 2, rsp_valid at accept+3, rsp_err=0.
- LOAD adr=0x0010 with the bench model returning 0xBEEF, ac delayed 5 cycles -> request held 5 cycles, rsp_dat=0xBEEF at accept+9.
- LOCK adr=0x3FF -> lock_adr=0x3FF and lock_en high until lock_ac; then UNLOCK 0x3FF -> unlock_en only, rsp_valid after ack.
- cmd_valid held high during a LOAD with second cmd STORE 0x0020 -> second command accepted only after rsp_valid; no write strobe during the LOAD.
- Reset asserted in ACCESS -> all outputs 0 on next edge, no rsp_valid, cmd_ready=1 after reset release.
- MEM_PORT_TIMEOUT_EN, TIMEOUT=4, LOCK never acked -> lock_en drops after 4 wait cycles, rsp_valid with rsp_err=1.
- MEM_PORT_TIMEOUT_EN, TIMEOUT=4, ac asserted exactly on the 4th wait cycle -> normal completion, rsp_err=0.
